// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register_file write port (we3/wa3/wd3) between
// the ALU and load writeback paths. Optional read forwarding under WR_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int CNT_W      = 16,
    parameter int RESET_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [XLEN-1:0]  req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [XLEN-1:0]  req1_data,
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [XLEN-1:0]  wd3,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2
);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    localparam prio_e            PRIO_INIT = (RESET_PRIO != 0) ? PRIO_REQ1 : PRIO_REQ0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    prio_e            prio_q, prio_d;
    logic             grant0, grant1;
    logic             we3_q, we3_d;
    logic [AW-1:0]    wa3_q, wa3_d;
    logic [XLEN-1:0]  wd3_q, wd3_d;
    logic [CNT_W-1:0] grant0Cnt_q, grant0Cnt_d;
    logic [CNT_W-1:0] grant1Cnt_q, grant1Cnt_d;

    // Priority only flips when both requesters compete, so a lone requester never steals it.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        prio_d = prio_q;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                if (prio_q == PRIO_REQ0) begin
                    grant0 = 1'b1;
                    prio_d = PRIO_REQ1;
                end else begin
                    grant1 = 1'b1;
                    prio_d = PRIO_REQ0;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // x0 writes are accepted and counted but never reach the write port.
    always_comb begin
        we3_d       = 1'b0;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        grant0Cnt_d = grant0Cnt_q;
        grant1Cnt_d = grant1Cnt_q;
        if (grant0) begin
            grant0Cnt_d = grant0Cnt_q + CNT_ONE;
            if (req0_addr != '0) begin
                we3_d = 1'b1;
                wa3_d = req0_addr;
                wd3_d = req0_data;
            end
        end else if (grant1) begin
            grant1Cnt_d = grant1Cnt_q + CNT_ONE;
            if (req1_addr != '0) begin
                we3_d = 1'b1;
                wa3_d = req1_addr;
                wd3_d = req1_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q      <= PRIO_INIT;
            we3_q       <= 1'b0;
            wa3_q       <= '0;
            wd3_q       <= '0;
            grant0Cnt_q <= '0;
            grant1Cnt_q <= '0;
        end else begin
            prio_q      <= prio_d;
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            grant0Cnt_q <= grant0Cnt_d;
            grant1Cnt_q <= grant1Cnt_d;
        end
    end

    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign grant0_cnt = grant0Cnt_q;
    assign grant1_cnt = grant1Cnt_q;

`ifdef WR_ARB_BYPASS_EN
    // Forward the write being committed this cycle, since register_file only sees it at the next edge.
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        if (we3_q && (wa3_q == ra1) && (ra1 != '0)) begin
            rd1 = wd3_q;
        end
        if (we3_q && (wa3_q == ra2) && (ra2 != '0)) begin
            rd2 = wd3_q;
        end
    end
`else
    logic unusedReadAddr;

    assign unusedReadAddr = ^{ra1, ra2};
    assign rd1            = rf_rd1;
    assign rd2            = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed corner cases, then randomized
// traffic checked against a transaction-level round-robin model.
module tb_regfile_write_arbiter;

    localparam int XLEN       = 32;
    localparam int AW         = 5;
    localparam int CNT_W      = 16;
    localparam int RESET_PRIO = 0;
    localparam int RAND_CYCLES = 400;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [AW-1:0]    req0_addr, req1_addr;
    logic [XLEN-1:0]  req0_data, req1_data;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [XLEN-1:0]  wd3;
    logic [CNT_W-1:0] grant0_cnt, grant1_cnt;
    logic [AW-1:0]    ra1, ra2;
    logic [XLEN-1:0]  rf_rd1, rf_rd2;
    logic [XLEN-1:0]  rd1, rd2;

    typedef struct {
        int unsigned     cyc;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t         expQ[$];
    wr_t         monEntry;
    int unsigned cyc;
    bit          monOn;
    int          vecs;
    int          miscompares;

    regfile_write_arbiter #(
        .XLEN(XLEN), .AW(AW), .CNT_W(CNT_W), .RESET_PRIO(RESET_PRIO)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
        .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd1(rd1), .rd2(rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecs++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s,
                                 input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        @(negedge clk);
        stall      = s;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle either the oldest expected write is due, or the port must be idle.
    always @(posedge clk) begin
        #1;
        if (monOn) begin
            if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                monEntry = expQ.pop_front();
                checkOutput("issue_we3", 64'(we3), 64'd1);
                checkOutput("issue_wa3", 64'(wa3), 64'(monEntry.addr));
                checkOutput("issue_wd3", 64'(wd3), 64'(monEntry.data));
            end else begin
                checkOutput("idle_we3", 64'(we3), 64'd0);
            end
        end
    end

    // Randomized phase with a transaction-level model: each requester holds one pending write.
    task automatic runRandom();
        bit              pend[2];
        logic [AW-1:0]   pAddr[2];
        logic [XLEN-1:0] pData[2];
        int              mPrio;
        int              winner;
        int unsigned     mCnt[2];
        wr_t             w;

        mPrio = RESET_PRIO;
        mCnt[0] = 0;
        mCnt[1] = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        monOn = 1'b1;
        for (int n = 0; n < RAND_CYCLES; n++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0)) begin
                    pend[r]  = 1'b1;
                    pAddr[r] = AW'($urandom_range(0, 3));
                    pData[r] = $urandom;
                end
            end
            stall      = ($urandom_range(0, 4) == 0);
            req0_valid = pend[0];
            req0_addr  = pAddr[0];
            req0_data  = pData[0];
            req1_valid = pend[1];
            req1_addr  = pAddr[1];
            req1_data  = pData[1];
            #1;
            winner = -1;
            if (!stall) begin
                if (pend[0] && pend[1]) begin
                    winner = mPrio;
                    mPrio  = 1 - mPrio;
                end else if (pend[0]) begin
                    winner = 0;
                end else if (pend[1]) begin
                    winner = 1;
                end
            end
            checkOutput("rand_ready0", 64'(req0_ready), 64'(winner == 0));
            checkOutput("rand_ready1", 64'(req1_ready), 64'(winner == 1));
            if (winner >= 0) begin
                mCnt[winner]++;
                pend[winner] = 1'b0;
                if (pAddr[winner] != '0) begin
                    w.cyc  = cyc + 1;
                    w.addr = pAddr[winner];
                    w.data = pData[winner];
                    expQ.push_back(w);
                end
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        stall      = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        monOn = 1'b0;
        checkOutput("rand_queue_drained", 64'(expQ.size()), 64'd0);
        checkOutput("rand_grant0_cnt", 64'(grant0_cnt), 64'(mCnt[0] % (1 << CNT_W)));
        checkOutput("rand_grant1_cnt", 64'(grant1_cnt), 64'(mCnt[1] % (1 << CNT_W)));
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        cyc         = 0;
        monOn       = 1'b0;
        reset       = 1'b1;
        stall       = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_addr   = '0;
        req1_addr   = '0;
        req0_data   = '0;
        req1_data   = '0;
        ra1         = '0;
        ra2         = '0;
        rf_rd1      = '0;
        rf_rd2      = '0;
        #12;
        reset = 1'b0;
        checkOutput("reset_we3", 64'(we3), 64'd0);
        checkOutput("reset_wa3", 64'(wa3), 64'd0);
        checkOutput("reset_wd3", 64'(wd3), 64'd0);
        checkOutput("reset_cnt0", 64'(grant0_cnt), 64'd0);
        checkOutput("reset_cnt1", 64'(grant1_cnt), 64'd0);

        // Single ALU write to x1
        applyStimulus(1'b0, 1'b1, 5'd1, 32'hAAAAAAAA, 1'b0, 5'd0, 32'h0);
        checkOutput("single_ready0", 64'(req0_ready), 64'd1);
        stepEdge();
        checkOutput("single_we3", 64'(we3), 64'd1);
        checkOutput("single_wa3", 64'(wa3), 64'd1);
        checkOutput("single_wd3", 64'(wd3), 64'hAAAAAAAA);
        checkOutput("single_cnt0", 64'(grant0_cnt), 64'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepEdge();
        checkOutput("single_we3_off", 64'(we3), 64'd0);
        checkOutput("single_wa3_hold", 64'(wa3), 64'd1);

        // Contested: alternating grants starting with requester 0
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'hDEADBEEF);
            checkOutput("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            checkOutput("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
            stepEdge();
            checkOutput("rr_we3", 64'(we3), 64'd1);
            checkOutput("rr_wa3", 64'(wa3), (i % 2 == 0) ? 64'd2 : 64'd3);
        end
        checkOutput("rr_cnt0", 64'(grant0_cnt), 64'd3);
        checkOutput("rr_cnt1", 64'(grant1_cnt), 64'd2);

        // x0 write: acknowledged and counted, never issued
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        checkOutput("x0_ready1", 64'(req1_ready), 64'd1);
        stepEdge();
        checkOutput("x0_we3", 64'(we3), 64'd0);
        checkOutput("x0_wa3_hold", 64'(wa3), 64'd3);
        checkOutput("x0_cnt1", 64'(grant1_cnt), 64'd3);

        // Stall with both valid, then requester 0 (prio holder) wins
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'hDEADBEEF);
            checkOutput("stall_ready0", 64'(req0_ready), 64'd0);
            checkOutput("stall_ready1", 64'(req1_ready), 64'd0);
            stepEdge();
            checkOutput("stall_we3", 64'(we3), 64'd0);
        end
        applyStimulus(1'b0, 1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'hDEADBEEF);
        checkOutput("unstall_ready0", 64'(req0_ready), 64'd1);
        checkOutput("unstall_ready1", 64'(req1_ready), 64'd0);
        stepEdge();
        checkOutput("unstall_wa3", 64'(wa3), 64'd2);

        // Read forwarding during the write cycle
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF);
        stepEdge();
        ra1    = 5'd3;
        ra2    = 5'd0;
        rf_rd1 = 32'h0;
        rf_rd2 = 32'h55555555;
        #1;
`ifdef WR_ARB_BYPASS_EN
        checkOutput("bypass_rd1", 64'(rd1), 64'hDEADBEEF);
`else
        checkOutput("bypass_rd1", 64'(rd1), 64'h0);
`endif
        checkOutput("bypass_rd2_x0", 64'(rd2), 64'h55555555);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        stepEdge();
        rf_rd1 = 32'h11111111;
        #1;
        checkOutput("bypass_rd1_idle", 64'(rd1), 64'h11111111);

        // Fresh reset, then randomized traffic
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        checkOutput("rereset_cnt0", 64'(grant0_cnt), 64'd0);
        runRandom();

        // Reset while a write is staged drops we3 immediately
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0);
        stepEdge();
        checkOutput("midreset_pre_we3", 64'(we3), 64'd1);
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midreset_we3", 64'(we3), 64'd0);
        checkOutput("midreset_wa3", 64'(wa3), 64'd0);
        checkOutput("midreset_cnt0", 64'(grant0_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
